// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types for the unified memory port arbiter.
// Holds arbiter state encoding, data_size codes and the default data width.
// Imported by mem_port_arbiter and mem_arb_timeout.
package cpu_mem_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_BYTE = 2'b01,
        SIZE_HALF = 2'b10
    } data_size_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// mem_arb_timeout: watchdog for one memory access; expire fires on the cycle that would reach TIMEOUT.
// Ports: clk/reset; clear (held while arbiter idle, so counter is 0 on access entry); run (in access, no ready).
// Latency: expire is combinational; arbiter registers it, so the abort ack lands TIMEOUT cycles after entry.
module mem_arb_timeout
    import cpu_mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // cnt counts waited cycles; when cnt==TIMEOUT-1 and still no ready, this cycle makes TIMEOUT.
    assign expire = run && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (if_*) and data access (dm_*).
// Ports: clk/reset; if_*/dm_* requester handshakes with stall outputs; mem_* unified memory port.
// Latency >= 2 cycles request->ack; requesters see stall until their ack. MEM_ARB_TIMEOUT_EN adds abort watchdog.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_err
);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state;
    logic [3:0] starve_cnt;
    logic       arb_open;
    logic       dm_wins;
    logic       if_wins;
    logic       expire;

    // No grant in a cycle carrying an ack: the completing requester gets one cycle to present its
    // next request before the other side is considered, which is what lets back-to-back data
    // accesses accumulate starve_cnt against a pending fetch.
    assign arb_open = (state == IDLE) && !if_ack && !dm_ack;
    // Data wins until starve_cnt hits the limit; the limit only bites while a fetch is waiting.
    assign dm_wins  = arb_open && dm_req && ((starve_cnt < STARVE_LIM) || !if_req);
    assign if_wins  = arb_open && if_req && !dm_wins;

    assign if_stall = if_req && !if_ack;
    assign dm_stall = dm_req && !dm_ack;

    always_comb begin
        mem_we    = 1'b0;
        mem_size  = 2'b00;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IF_ACC: begin
                mem_size = SIZE_WORD;
                mem_addr = if_addr;
            end
            DM_ACC: begin
                mem_we    = dm_we;
                mem_size  = dm_size;
                mem_addr  = dm_addr;
                mem_wdata = dm_wdata;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .run    ((state != IDLE) && !mem_ready),
        .expire (expire)
    );
`else
    assign expire = 1'b0;
    wire unused_timeout = (TIMEOUT != 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_en     <= 1'b0;
            mem_err    <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (dm_wins) begin
                        state      <= DM_ACC;
                        mem_en     <= 1'b1;
                        starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
                    end else if (if_wins) begin
                        state      <= IF_ACC;
                        mem_en     <= 1'b1;
                        starve_cnt <= 4'd0;
                    end
                end
                IF_ACC: begin
                    if (mem_ready || expire) begin
                        state    <= IDLE;
                        mem_en   <= 1'b0;
                        if_ack   <= 1'b1;
                        if_rdata <= mem_ready ? mem_rdata : '0;
                        mem_err  <= !mem_ready;
                    end
                end
                DM_ACC: begin
                    if (mem_ready || expire) begin
                        state    <= IDLE;
                        mem_en   <= 1'b0;
                        dm_ack   <= 1'b1;
                        dm_rdata <= (mem_ready && !dm_we) ? mem_rdata : '0;
                        mem_err  <= !mem_ready;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// Table of single accesses plus scoreboarded multi-requester, reset and wait/timeout sequences.
// Memory responder answers mem_en after wait_cycles unless mem_hold is set.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int DW = 32;
    localparam int SMAX = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_ack, if_stall;
    logic [DW-1:0] if_addr, if_rdata;
    logic          dm_req, dm_we, dm_ack, dm_stall;
    logic [1:0]    dm_size;
    logic [DW-1:0] dm_addr, dm_wdata, dm_rdata;
    logic          mem_en, mem_we, mem_ready, mem_err;
    logic [1:0]    mem_size;
    logic [DW-1:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Memory contents model: fixed instruction at 0x10, otherwise {addr[15:0], ~addr[15:0]}.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'hE3A0_1005 : {a[15:0], ~a[15:0]};
    endfunction

    int wait_cycles = 0;
    int wcnt = 0;
    bit mem_hold = 0;

    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_en && !mem_hold) begin
                if (wcnt >= wait_cycles) begin
                    mem_ready = 1'b1;
                    wcnt = 0;
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
            mem_rdata = mem_model(mem_addr);
        end
    end

    typedef struct {
        bit          is_dm;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wt;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    // Starts at a sample point (#1 after posedge) with the DUT idle; ends at the ack sample point.
    task automatic run_single(input vec_t v, input int idx);
        int  n;
        bit  got;
        string t;
        t = $sformatf("v%0d", idx);
        wait_cycles = v.wt;
        if (v.is_dm) begin
            dm_req = 1'b1; dm_we = v.we; dm_size = v.size; dm_addr = v.addr; dm_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        chk({t, "_stall_c0"}, v.is_dm ? dm_stall : if_stall, 1);
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (v.is_dm ? dm_ack : if_ack) begin
                got = 1;
                chk({t, "_latency"}, 32'(n), 32'(v.exp_lat));
                chk({t, "_rdata"}, v.is_dm ? dm_rdata : if_rdata, v.exp_rdata);
                chk({t, "_stall_ack"}, v.is_dm ? dm_stall : if_stall, 0);
                chk({t, "_en_ack"}, mem_en, 0);
            end else begin
                chk({t, "_mem_en"}, mem_en, 1);
                chk({t, "_mem_addr"}, mem_addr, v.addr);
                chk({t, "_mem_we"}, mem_we, v.is_dm & v.we);
                chk({t, "_mem_size"}, mem_size, v.is_dm ? v.size : 2'b00);
                chk({t, "_mem_wdata"}, mem_wdata, v.is_dm ? v.wdata : 32'h0);
            end
        end
        if (!got) fail_now({t, "_ack_wait"});
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        logic [1:0]  size;
    } req_t;

    req_t        if_pend[$];
    req_t        dm_pend[$];
    logic [31:0] if_exp[$];
    logic [31:0] dm_exp[$];
    req_t        gnt_exp[$];

    task automatic push_if(input logic [31:0] a);
        if_pend.push_back('{a, 1'b0, 32'h0, 2'b00});
        if_exp.push_back(mem_model(a));
    endtask

    task automatic push_dm(input logic [31:0] a, input bit we, input logic [31:0] wd);
        dm_pend.push_back('{a, we, wd, 2'b00});
        dm_exp.push_back(we ? 32'h0 : mem_model(a));
    endtask

    task automatic exp_gnt(input logic [31:0] a, input bit we, input logic [31:0] wd);
        gnt_exp.push_back('{a, we, wd, 2'b00});
    endtask

    task automatic present();
        if_req = (if_pend.size() > 0);
        if_addr = if_req ? if_pend[0].addr : 32'h0;
        dm_req = (dm_pend.size() > 0);
        if (dm_req) begin
            dm_addr = dm_pend[0].addr; dm_we = dm_pend[0].we; dm_wdata = dm_pend[0].wdata; dm_size = dm_pend[0].size;
        end
    endtask

    task automatic engine(input string tag, input int budget);
        int   cyc;
        bit   prev_en;
        req_t g;
        cyc = 0;
        prev_en = 0;
        present();
        while ((if_pend.size() > 0 || dm_pend.size() > 0) && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_en && !prev_en) begin
                if (gnt_exp.size() == 0) begin
                    fail_now({tag, "_unexpected_grant"});
                end else begin
                    g = gnt_exp.pop_front();
                    chk({tag, "_gnt_addr"}, mem_addr, g.addr);
                    chk({tag, "_gnt_we"}, mem_we, g.we);
                    chk({tag, "_gnt_wdata"}, mem_wdata, g.wdata);
                end
            end
            prev_en = mem_en;
            if (if_req && !if_ack) chk({tag, "_if_stall"}, if_stall, 1);
            if (if_ack) begin
                if (if_exp.size() == 0) fail_now({tag, "_extra_if_ack"});
                else begin
                    chk({tag, "_if_rdata"}, if_rdata, if_exp.pop_front());
                    void'(if_pend.pop_front());
                end
            end
            if (dm_ack) begin
                if (dm_exp.size() == 0) fail_now({tag, "_extra_dm_ack"});
                else begin
                    chk({tag, "_dm_rdata"}, dm_rdata, dm_exp.pop_front());
                    void'(dm_pend.pop_front());
                end
            end
            present();
        end
        if (if_pend.size() > 0 || dm_pend.size() > 0) fail_now({tag, "_drain"});
        chk({tag, "_grants_left"}, 32'(gnt_exp.size()), 0);
        if_pend.delete(); dm_pend.delete(); if_exp.delete(); dm_exp.delete(); gnt_exp.delete();
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        int   n;
        int   acks;
        bit   got;

        tbl[0] = '{1'b0, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 0, 32'hE3A0_1005, 2};
        tbl[1] = '{1'b1, 1'b0, 2'b01, 32'h0000_0204, 32'h0, 0, 32'h0204_FDFB, 2};
        tbl[2] = '{1'b1, 1'b1, 2'b10, 32'h0000_0300, 32'h1234_5678, 1, 32'h0, 3};
        tbl[3] = '{1'b1, 1'b0, 2'b00, 32'h0000_0400, 32'h0, 3, 32'h0400_FBFF, 5};
        tbl[4] = '{1'b0, 1'b0, 2'b00, 32'h0000_1000, 32'h0, 2, 32'h1000_EFFF, 4};
        tbl[5] = '{1'b1, 1'b0, 2'b00, 32'h0000_0500, 32'h0, 0, 32'h0500_FAFF, 2};

        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_size = 2'b00; dm_addr = '0; dm_wdata = '0;
        #1 reset = 1'b1;
        #2;
        chk("rst_mem_en", mem_en, 0);
        chk("rst_if_ack", if_ack, 0);
        chk("rst_dm_ack", dm_ack, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_stall", if_stall, 0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run_single(tbl[i], i);
            @(posedge clk);
            #1;
        end

        // Simultaneous store + fetch: data first, then fetch.
        wait_cycles = 0;
        push_dm(32'h100, 1'b1, 32'hDEAD_BEEF);
        push_if(32'h20);
        exp_gnt(32'h100, 1'b1, 32'hDEAD_BEEF);
        exp_gnt(32'h20, 1'b0, 32'h0);
        engine("both", 60);
        @(posedge clk);
        #1;

        // Back-to-back loads against a held fetch: 4 data grants, fetch, 4 more, fetch, last load.
        for (int i = 0; i < 9; i++) push_dm(32'h800 + 32'(4 * i), 1'b0, 32'h0);
        push_if(32'h40);
        push_if(32'h44);
        for (int i = 0; i < 4; i++) exp_gnt(32'h800 + 32'(4 * i), 1'b0, 32'h0);
        exp_gnt(32'h40, 1'b0, 32'h0);
        for (int i = 4; i < 8; i++) exp_gnt(32'h800 + 32'(4 * i), 1'b0, 32'h0);
        exp_gnt(32'h44, 1'b0, 32'h0);
        exp_gnt(32'h820, 1'b0, 32'h0);
        engine("starve", 200);
        @(posedge clk);
        #1;

        // Reset in the middle of a fetch access.
        wait_cycles = 10;
        if_req = 1'b1;
        if_addr = 32'h80;
        @(posedge clk);
        #1;
        chk("rstmid_pre_en", mem_en, 1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_en", mem_en, 0);
        chk("rstmid_addr", mem_addr, 0);
        acks = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (if_ack) acks++;
        end
        chk("rstmid_no_ack", 32'(acks), 0);
        wait_cycles = 0;
        #2 reset = 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (if_ack) got = 1;
        end
        if (!got) fail_now("rstmid_after_ack");
        chk("rstmid_after_lat", 32'(n), 2);
        chk("rstmid_after_rdata", if_rdata, 32'h0080_FF7F);
        if_req = 1'b0;
        @(posedge clk);
        #1;

        // Memory never ready.
        mem_hold = 1;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'b00; dm_addr = 32'h600; dm_wdata = 32'h0;
`ifdef MEM_ARB_TIMEOUT_EN
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (dm_ack) got = 1;
        end
        if (!got) fail_now("to_ack_wait");
        chk("to_latency", 32'(n), 17);
        chk("to_mem_err", mem_err, 1);
        chk("to_dm_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        mem_hold = 0;
        @(posedge clk);
        #1;
        chk("to_err_pulse", mem_err, 0);
`else
        acks = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (dm_ack || mem_err) acks++;
        end
        chk("hold_no_ack", 32'(acks), 0);
        chk("hold_mem_en", mem_en, 1);
        chk("hold_stall", dm_stall, 1);
        mem_hold = 0;
        n = 0;
        got = 0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (dm_ack) got = 1;
        end
        if (!got) fail_now("hold_release_ack");
        chk("hold_rdata", dm_rdata, 32'h0600_F9FF);
        chk("hold_mem_err", mem_err, 0);
        dm_req = 1'b0;
`endif

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
